// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit direction counters; define BP_STATS_EN for update/mispredict counters
module branch_predictor #(
  parameter int DATA_WIDTH = 32,
  parameter int ENTRIES    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] lookup_pc,
  output logic                  predict_valid,
  output logic                  predict_taken,
  output logic [DATA_WIDTH-1:0] predict_target,
  input  logic                  update_en,
  input  logic [DATA_WIDTH-1:0] update_pc,
  input  logic                  update_taken,
  input  logic [DATA_WIDTH-1:0] update_target,
  input  logic                  update_mispredict,
  output logic [31:0]           stat_updates,
  output logic [31:0]           stat_mispredicts
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = DATA_WIDTH - IDX_W - 2;
  logic                  valid_q  [ENTRIES];
  logic [TAG_W-1:0]      tag_q    [ENTRIES];
  logic [DATA_WIDTH-1:0] target_q [ENTRIES];
  logic [1:0]            ctr_q    [ENTRIES];
  logic [IDX_W-1:0]      l_idx, u_idx;
  logic [TAG_W-1:0]      l_tag, u_tag;
  logic                  l_hit, u_hit;
  logic [1:0]            ctr_d;
  logic                  unused_bits;
  assign l_idx = lookup_pc[IDX_W+1:2];
  assign l_tag = lookup_pc[DATA_WIDTH-1:IDX_W+2];
  assign u_idx = update_pc[IDX_W+1:2];
  assign u_tag = update_pc[DATA_WIDTH-1:IDX_W+2];
  always_comb begin
    l_hit          = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    u_hit          = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    predict_valid  = l_hit;
    predict_taken  = l_hit && ctr_q[l_idx][1];
    predict_target = l_hit ? target_q[l_idx] : '0;
    ctr_d          = update_taken ? ((ctr_q[u_idx] == 2'b11) ? 2'b11 : ctr_q[u_idx] + 2'd1)
                                  : ((ctr_q[u_idx] == 2'b00) ? 2'b00 : ctr_q[u_idx] - 2'd1);
  end
  // Lookup reads the registered table only, so a same-cycle update is seen next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (update_en && (u_hit || update_taken)) begin
      ctr_q[u_idx] <= u_hit ? ctr_d : 2'b10;
      if (update_taken) begin
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= update_target;
      end
    end
  end
`ifdef BP_STATS_EN
  logic [31:0] stat_updates_q, stat_mispredicts_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_updates_q     <= '0;
      stat_mispredicts_q <= '0;
    end else if (update_en) begin
      stat_updates_q <= stat_updates_q + 32'd1;
      if (update_mispredict) stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
    end
  end
  assign stat_updates     = stat_updates_q;
  assign stat_mispredicts = stat_mispredicts_q;
  assign unused_bits      = ^{lookup_pc[1:0], update_pc[1:0]};
`else
  assign stat_updates     = '0;
  assign stat_mispredicts = '0;
  assign unused_bits      = ^{lookup_pc[1:0], update_pc[1:0], update_mispredict};
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed table, reset/stat sequences and randomized run against a behavioural BTB model
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        predict_valid, predict_taken;
  logic [31:0] predict_target;
  logic        update_en = 1'b0;
  logic [31:0] update_pc = '0;
  logic        update_taken = 1'b0;
  logic [31:0] update_target = '0;
  logic        update_mispredict = 1'b0;
  logic [31:0] stat_updates, stat_mispredicts;
  int n_chk = 0;
  int n_fail = 0;

  branch_predictor #(.DATA_WIDTH(32), .ENTRIES(16)) dut (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
    .predict_valid(predict_valid), .predict_taken(predict_taken), .predict_target(predict_target),
    .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_mispredict(update_mispredict),
    .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  // Model: each slot remembers the full word address above the index (pc>>6) as its key.
  bit          m_valid [16];
  logic [31:0] m_key   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  logic [31:0] m_upd, m_mis;

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_key[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_upd = 0; m_mis = 0;
  endfunction

  function automatic int m_idx(logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    return m_valid[m_idx(pc)] && (m_key[m_idx(pc)] == (pc >> 6));
  endfunction

  function automatic void m_update(logic en, logic [31:0] pc, logic tk, logic [31:0] tgt, logic mis);
    int i;
    if (!en) return;
    i = m_idx(pc);
    m_upd = m_upd + 1;
    if (mis) m_mis = m_mis + 1;
    if (m_hit(pc)) begin
      m_ctr[i] = tk ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
      if (tk) m_tgt[i] = tgt;
    end else if (tk) begin
      m_valid[i] = 1; m_key[i] = pc >> 6; m_tgt[i] = tgt; m_ctr[i] = 2;
    end
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_model(string nm);
    bit h;
    h = m_hit(lookup_pc);
    chk({nm, "_valid"}, {31'd0, predict_valid}, {31'd0, h});
    chk({nm, "_taken"}, {31'd0, predict_taken}, {31'd0, h && (m_ctr[m_idx(lookup_pc)] >= 2)});
    chk({nm, "_target"}, predict_target, h ? m_tgt[m_idx(lookup_pc)] : 32'd0);
`ifdef BP_STATS_EN
    chk({nm, "_stat_upd"}, stat_updates, m_upd);
    chk({nm, "_stat_mis"}, stat_mispredicts, m_mis);
`else
    chk({nm, "_stat_upd"}, stat_updates, 32'd0);
    chk({nm, "_stat_mis"}, stat_mispredicts, 32'd0);
`endif
  endtask

  task automatic apply(logic en, logic [31:0] pc, logic tk, logic [31:0] tgt, logic mis, logic [31:0] lk);
    @(negedge clk);
    update_en = en; update_pc = pc; update_taken = tk; update_target = tgt;
    update_mispredict = mis; lookup_pc = lk;
    #1;
  endtask

  task automatic commit();
    @(posedge clk);
    if (rst) m_update(update_en, update_pc, update_taken, update_target, update_mispredict);
  endtask

  task automatic do_reset();
    @(negedge clk);
    update_en = 0;
    #2 rst = 0;
    m_reset();
    @(negedge clk);
    rst = 1;
  endtask

  task automatic sweep_zero(string nm);
    for (int p = 0; p <= 'h3C; p += 4) begin
      lookup_pc = p;
      #1;
      chk({nm, "_valid"}, {31'd0, predict_valid}, 32'd0);
      chk({nm, "_taken"}, {31'd0, predict_taken}, 32'd0);
      chk({nm, "_target"}, predict_target, 32'd0);
    end
  endtask

  typedef struct {
    logic en; logic [31:0] pc; logic tk; logic [31:0] tgt; logic mis;
    logic [31:0] lk; logic ev; logic et; logic [31:0] etgt;
  } vec_t;
  vec_t vt [23];

  initial begin
    vt[0]  = '{1, 'h10, 1, 'h80, 1, 'h10, 0, 0, 'h0};
    vt[1]  = '{0, 'h00, 0, 'h00, 0, 'h10, 1, 1, 'h80};
    vt[2]  = '{0, 'h00, 0, 'h00, 0, 'h50, 0, 0, 'h0};
    vt[3]  = '{1, 'h10, 0, 'h00, 0, 'h10, 1, 1, 'h80};
    vt[4]  = '{1, 'h10, 0, 'h00, 0, 'h10, 1, 0, 'h80};
    vt[5]  = '{1, 'h10, 0, 'h00, 0, 'h10, 1, 0, 'h80};
    vt[6]  = '{0, 'h00, 0, 'h00, 0, 'h10, 1, 0, 'h80};
    vt[7]  = '{1, 'h10, 1, 'h84, 0, 'h10, 1, 0, 'h80};
    vt[8]  = '{1, 'h10, 1, 'h84, 0, 'h10, 1, 0, 'h84};
    vt[9]  = '{1, 'h10, 1, 'h84, 0, 'h10, 1, 1, 'h84};
    vt[10] = '{1, 'h10, 1, 'h84, 0, 'h10, 1, 1, 'h84};
    vt[11] = '{0, 'h00, 0, 'h00, 0, 'h10, 1, 1, 'h84};
    vt[12] = '{1, 'h10, 0, 'h00, 0, 'h10, 1, 1, 'h84};
    vt[13] = '{0, 'h00, 0, 'h00, 0, 'h10, 1, 1, 'h84};
    vt[14] = '{1, 'h20, 0, 'h00, 1, 'h20, 0, 0, 'h0};
    vt[15] = '{0, 'h00, 0, 'h00, 0, 'h20, 0, 0, 'h0};
    vt[16] = '{1, 'h24, 1, 'h100, 0, 'h24, 0, 0, 'h0};
    vt[17] = '{0, 'h00, 0, 'h00, 0, 'h24, 1, 1, 'h100};
    vt[18] = '{1, 'h13, 0, 'h00, 0, 'h12, 1, 1, 'h84};
    vt[19] = '{0, 'h00, 0, 'h00, 0, 'h11, 1, 0, 'h84};
    vt[20] = '{1, 'h50, 1, 'h200, 0, 'h50, 0, 0, 'h0};
    vt[21] = '{0, 'h00, 0, 'h00, 0, 'h10, 0, 0, 'h0};
    vt[22] = '{0, 'h00, 0, 'h00, 0, 'h50, 1, 1, 'h200};

    m_reset();
    #1;
    check_model("reset_initial");
    @(negedge clk);
    @(negedge clk) rst = 1;

    // Directed table: expectations are the pre-update view of each cycle.
    for (int v = 0; v < 23; v++) begin
      apply(vt[v].en, vt[v].pc, vt[v].tk, vt[v].tgt, vt[v].mis, vt[v].lk);
      chk($sformatf("vec%0d_valid", v), {31'd0, predict_valid}, {31'd0, vt[v].ev});
      chk($sformatf("vec%0d_taken", v), {31'd0, predict_taken}, {31'd0, vt[v].et});
      chk($sformatf("vec%0d_target", v), predict_target, vt[v].etgt);
      commit();
    end
    apply(0, 0, 0, 0, 0, 'h24);
`ifdef BP_STATS_EN
    chk("table_stat_upd", stat_updates, 32'd13);
    chk("table_stat_mis", stat_mispredicts, 32'd2);
`else
    chk("table_stat_upd", stat_updates, 32'd0);
    chk("table_stat_mis", stat_mispredicts, 32'd0);
`endif

    // Mid-run reset with an update in flight across an edge.
    apply(1, 'h30, 1, 'h44, 1, 'h24);
    #2 rst = 0;
    m_reset();
    sweep_zero("rst_low");
    chk("rst_low_stat_upd", stat_updates, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1; update_en = 0;
    #1;
    sweep_zero("rst_rel");
    chk("rst_rel_stat_upd", stat_updates, 32'd0);
    chk("rst_rel_stat_mis", stat_mispredicts, 32'd0);

    // Five updates, two flagged as mispredicts.
    for (int k = 0; k < 5; k++) begin
      apply(1, 32'h40 + 32'(k * 4), 1, 32'h300 + 32'(k), (k == 1 || k == 3) ? 1'b1 : 1'b0, 'h40);
      check_model($sformatf("stat%0d", k));
      commit();
    end
    apply(0, 0, 0, 0, 0, 'h44);
    check_model("stat_end");
`ifdef BP_STATS_EN
    chk("stat5_upd", stat_updates, 32'd5);
    chk("stat5_mis", stat_mispredicts, 32'd2);
    force dut.stat_updates_q = 32'hFFFF_FFFF;
    force dut.stat_mispredicts_q = 32'hFFFF_FFFF;
    #1;
    release dut.stat_updates_q;
    release dut.stat_mispredicts_q;
    m_upd = 32'hFFFF_FFFF; m_mis = 32'hFFFF_FFFF;
    #1;
    check_model("pre_wrap");
    apply(1, 'h48, 0, 0, 1, 'h48);
    commit();
    apply(0, 0, 0, 0, 0, 'h48);
    check_model("wrap");
    chk("wrap_upd_zero", stat_updates, 32'd0);
`else
    chk("stat5_upd", stat_updates, 32'd0);
    chk("stat5_mis", stat_mispredicts, 32'd0);
`endif

    // Randomized traffic over 4 tags x 16 indices so hits, conflicts and evictions all occur.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      logic [31:0] upc, lpc;
      upc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      lpc = ($urandom_range(0, 3) == 0) ? upc :
            (($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
      apply(1'($urandom_range(0, 3) != 0), upc, 1'($urandom_range(0, 1)),
            $urandom, 1'($urandom_range(0, 4) == 0), lpc);
      check_model($sformatf("rand%0d", c));
      commit();
    end
    apply(0, 0, 0, 0, 0, 0);
    check_model("rand_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters that drives the fetch stage's `predict_valid`, `predict_taken` and `predict_target` inputs.
- Fetch presents its current PC and receives a prediction in the same cycle.
- The execute stage writes resolved branch outcomes back one cycle later.
- Sits beside fetch in the IF stage; updates come from the EX/hazard path that also drives `PCSrc`/`Hazard_target`.

## Interface
- `DATA_WIDTH`, 32: PC and target width.
- `ENTRIES`, 16: BTB depth; power of two, 2..256.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset (asserted when 0).
- `lookup_pc`  input  DATA_WIDTH  current fetch PC (`pc_out` of fetch).
- `predict_valid`  output  1  BTB hit for `lookup_pc`.
- `predict_taken`  output  1  hit and counter predicts taken.
- `predict_target`  output  DATA_WIDTH  stored target on hit; 0 otherwise.
- `update_en`  input  1  resolved control-flow instruction this cycle.
- `update_pc`  input  DATA_WIDTH  PC of the resolved branch.
- `update_taken`  input  1  actual outcome.
- `update_target`  input  DATA_WIDTH  actual target.
- `update_mispredict`  input  1  EX detected a misprediction (statistics only).
- `stat_updates`  output  32  count of accepted updates.
- `stat_mispredicts`  output  32  count of mispredicts.

## Operation
- Index: `pc[IDX_W+1:2]`, where IDX_W = log2(ENTRIES).
- Tag: `pc[DATA_WIDTH-1:IDX_W+2]`. `pc[1:0]` is ignored.
- Per entry: valid bit, tag, target, 2-bit counter with states 00 SNT, 01 WNT, 10 WT, 11 ST.
- Lookup is purely combinational:
  - hit = valid[idx] && tag match.
  - `predict_valid` = hit.
  - `predict_taken` = hit && ctr[1].
  - `predict_target` = hit ? target : 0.
- Update, on the clock edge when `update_en` = 1:
  - Hit: counter increments, saturating at 11, if `update_taken`; otherwise decrements, saturating at 00. If `update_taken`, the target is overwritten with `update_target`.
  - Miss with `update_taken` = 1: allocate. Set valid, write the tag and target, counter = 10 (WT). Any previous occupant is evicted unconditionally.
  - Miss with `update_taken` = 0: no table change.
- Simultaneous lookup and update to the same index: lookup returns the pre-update contents. There is no write-through bypass.
- `update_pc` bits [1:0] are ignored.
- `update_en` = 0: table and statistics hold.

## Timing
- Lookup latency: 0 cycles (combinational from `lookup_pc`).
- Update latency: the written entry is visible to lookup on the cycle after the update edge.
- Reset, asynchronous on `rst` = 0:
  - All valid bits cleared; all counters 01; tags and targets 0.
  - Statistics cleared to 0.
  - Outputs during and after reset: `predict_valid` = 0, `predict_taken` = 0, `predict_target` = 0, `stat_*` = 0.
- Reset asserted mid-operation: any in-flight update on that edge is discarded.
- Reset release is synchronous to `clk`. The first update is accepted on the first rising edge with `rst` = 1.
- No stall input. Fetch PC hold (`PC_en` = 0) simply repeats the same lookup.

## Configuration
- Macro: `BP_STATS_EN`.
- Defined:
  - `stat_updates` increments on every `update_en`.
  - `stat_mispredicts` increments when `update_en && update_mispredict`.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
- Undefined:
  - No counter flops are instantiated; both outputs are tied to 0.
  - `update_mispredict` is unused; lint waiver required.

## Test plan
- Reset: drive `rst` = 0 mid-run, then sweep `lookup_pc` 0x0..0x3C → `predict_valid` = 0, `predict_taken` = 0 and `predict_target` = 0 for every PC.
- Allocate: update pc = 0x10, taken, target = 0x80 → next cycle lookup 0x10 gives valid = 1, taken = 1, target = 0x80. Lookup 0x50 (same index, different tag, ENTRIES = 16) gives valid = 0.
- Saturation: three not-taken updates to 0x10 → counter goes 10 → 01 → 00 → 00. `predict_taken` = 0 after the first; `predict_valid` stays 1. Four taken updates → counter 11; `predict_taken` = 1 from the second.
- Not-taken miss: update pc = 0x20, not taken → lookup 0x20 gives valid = 0.
- Same-cycle update and lookup: allocate 0x24 while lookup 0x24 → valid = 0 that cycle, valid = 1 the next cycle.
- With `BP_STATS_EN`: 5 updates, 2 with `update_mispredict` → `stat_updates` = 5, `stat_mispredicts` = 2. Preload the counter near 0xFFFFFFFF and check wrap to 0. Without the macro, both stay 0.
